ram_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters (port 0, port 1).
- Each requester issues a read or write with a req/ack handshake. The arbiter picks a requester, sequences the RAM access, and returns an ack (plus read data for reads).
- Sits between the two client blocks and the RAM instance. It is the only driver of the RAM's we/addr/data_in.

---
 rtl/ram_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 27 ++
 rtl/ram_port_arbiter.sv | 87 ++++++++
 tb/tb_ram_port_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding, port indices and default widths shared by ram_port_arbiter and rr_arb2.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_e;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant with a round-robin priority pointer.
// Defining RAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority and removes the pointer.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic last_i,
  output logic gnt_o
);
`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst_n, upd_i, last_i, req1_i};
  assign gnt_o = req0_i ? PORT0 : PORT1;
`else
  logic ptr_q, ptr_d;
  // After a completed access the other port gets priority.
  assign ptr_d = upd_i ? ~last_i : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= PORT0;
    else ptr_q <= ptr_d;
  assign gnt_o = (req0_i && req1_i) ? ptr_q : (req1_i ? PORT1 : PORT0);
`endif
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two req/ack requesters.
// Arbitration is round-robin unless RAM_ARB_FIXED_PRIO_EN is defined (see rr_arb2).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  state_e state_q, state_d;
  logic gnt, grant, gnt_q, gnt_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (req0),
    .req1_i (req1),
    .upd_i  (state_q == DONE),
    .last_i (gnt_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req0 || req1) ? ISSUE : IDLE;
      ISSUE:   state_d = we_q ? DONE : RWAIT;
      RWAIT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The granted command is latched so requester changes after the grant are ignored;
  // the address/wdata registers drive the RAM directly and hold between accesses.
  assign grant   = (state_q == IDLE) && (req0 || req1);
  assign gnt_d   = grant ? gnt : gnt_q;
  assign we_d    = grant ? (gnt ? we1 : we0) : we_q;
  assign addr_d  = grant ? (gnt ? addr1 : addr0) : addr_q;
  assign wdata_d = (grant && we_d) ? (gnt ? wdata1 : wdata0) : wdata_q;
  assign rdata_d = (state_q == RWAIT) ? ram_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

  assign ram_we    = (state_q == ISSUE) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = state_q != IDLE;
  assign ack0      = (state_q == DONE) && (gnt_q == PORT0);
  assign ack1      = (state_q == DONE) && (gnt_q == PORT1);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench with a behavioural RAM and an ack-ordered scoreboard.
module tb_ram_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic ack0, ack1, busy, ram_we;
  logic [3:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0] mem [16] = '{7: 4'h3, default: 4'h0};
  int checks = 0, failures = 0;

  typedef struct packed {logic p; logic rd; logic [3:0] d;} exp_t;
  exp_t sb[$];

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (ack0 || ack1) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e.p));
        if (e.rd) chk("rdata", 32'(rdata), 32'(e.d));
      end
    end
  end

  task automatic wait_ack(input logic p, input int lat, input string tag, input logic chg, output int wes);
    int n = 0;
    wes = 0;
    do begin
      @(negedge clk);
      n++;
      wes += int'(ram_we);
      if (chg && n == 1) begin
        if (p) addr1 = '0;
        else addr0 = '0;
      end
    end while (!(p ? ack1 : ack0) && n < 12);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic access(input logic p, input logic w, input logic [3:0] a, input logic [3:0] d,
                        input logic chg, input string tag);
    int wes;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    sb.push_back('{p, !w, d});
    wait_ack(p, w ? 2 : 3, tag, chg, wes);
    chk({tag, "_we_cycles"}, 32'(wes), 32'(w));
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c0, c1, n, wes;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 4'd3, 4'hA, 1'b0, "wr0");
    access(1'b0, 1'b0, 4'd3, 4'hA, 1'b0, "rd0");
    chk("mem3", 32'(mem[3]), 32'hA);
    // Abort a read while it waits for RAM data.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_outputs", 32'({ack0, ack1, busy, ram_we}), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Simultaneous writes right after reset: port 0 first.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 4'h5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 4'h6;
    sb.push_back('{1'b0, 1'b0, 4'h5});
    sb.push_back('{1'b1, 1'b0, 4'h6});
    wait_ack(1'b0, 2, "sim0", 1'b0, wes);
    req0 = 1'b0;
    wait_ack(1'b1, 3, "sim1", 1'b0, wes);
    req1 = 1'b0;
    @(negedge clk);
    chk("mem1", 32'(mem[1]), 32'h5);
    chk("mem2", 32'(mem[2]), 32'h6);
    // Continuous contention: eight reads with both requests held.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      sb.push_back('{1'b0, 1'b1, 4'h5});
`else
      sb.push_back((i % 2) ? '{1'b1, 1'b1, 4'h6} : '{1'b0, 1'b1, 4'h5});
`endif
    end
    c0 = 0; c1 = 0; n = 0;
    while (c0 + c1 < 8 && n < 100) begin
      @(negedge clk);
      n++;
      c0 += int'(ack0);
      c1 += int'(ack1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("cont_acks0", 32'(c0), 32'd8);
    chk("cont_acks1", 32'(c1), 32'd0);
`else
    chk("cont_acks0", 32'(c0), 32'd4);
    chk("cont_acks1", 32'(c1), 32'd4);
`endif
    access(1'b1, 1'b0, 4'd7, 4'h3, 1'b1, "latch");
    repeat (10) begin
      @(negedge clk);
      chk("idle", 32'({busy, ram_we, ack0, ack1}), 32'd0);
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
